// File: rtl/logic_prim_pkg.sv
// logic_prim_pkg: shared types and helpers for the logic primitive unit.
//   op_e     : opcode encoding carried on in_op
//   state_e  : packet state (single-beat idle / accumulating)
//   base_op  : per-bit AND/OR/XOR selected by opcode; the inverted
//              opcodes 3-5 share the base function of opcodes 0-2
//   is_inverted / is_fold_op : opcode classification helpers
package logic_prim_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_BUF    = 3'd6,
    OP_BUFIF1 = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Bit-level so any operand width can loop over it without truncation.
  function automatic logic base_op(input op_e op, input logic x, input logic y);
    case (op)
      OP_AND, OP_NAND: return x & y;
      OP_OR,  OP_NOR:  return x | y;
      OP_XOR, OP_XNOR: return x ^ y;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic is_inverted(input op_e op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

  // Only the six gate opcodes can be folded across beats.
  function automatic logic is_fold_op(input op_e op);
    return (op != OP_BUF) && (op != OP_BUFIF1);
  endfunction

endpackage

// File: rtl/logic_prim_alu.sv
// logic_prim_alu: purely combinational single-beat primitive evaluation.
//   op   in  3      opcode (see op_e)
//   a    in  WIDTH  operand A
//   b    in  WIDTH  operand B
//   en   in  WIDTH  per-bit enable (BUFIF1 only)
//   data out WIDTH  result; BUFIF1 undriven bits read 0
//   oe   out WIDTH  output-enable mask; all ones except for BUFIF1
module logic_prim_alu
  import logic_prim_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] en,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] oe
);

  // Select the primitive; gate ops are built bit by bit from base_op.
  always_comb begin
    data = {WIDTH{1'b0}};
    oe   = {WIDTH{1'b1}};
    case (op_e'(op))
      OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR: begin
        for (int i = 0; i < WIDTH; i++) begin
          data[i] = base_op(op_e'(op), a[i], b[i]) ^ is_inverted(op_e'(op));
        end
      end
      OP_BUF: begin
        data = a;
      end
      OP_BUFIF1: begin
        data = a & en;
        oe   = en;
      end
      default: begin
        data = {WIDTH{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/logic_prim_unit.sv
// logic_prim_unit: handshaked, registered logic primitive unit with an
// optional multi-beat accumulate (fold) mode.
//   clk, rst                      clock / async active-high reset
//   in_valid, in_ready            input beat handshake
//   in_op, in_acc, in_last        opcode, accumulate request, packet end
//   in_a, in_b, in_en             operands and BUFIF1 enable
//   out_valid, out_ready          result handshake
//   out_data, out_oe, out_count   result, enable mask, beats folded
module logic_prim_unit
  import logic_prim_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_oe,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state, state_nxt;
  op_e              acc_op, acc_op_nxt;
  logic [WIDTH-1:0] acc, acc_nxt, folded;
  logic [CNT_W-1:0] count, count_nxt, count_inc;
  logic [WIDTH-1:0] alu_data, alu_oe;
  logic [WIDTH-1:0] emit_data, emit_oe;
  logic [CNT_W-1:0] emit_count;
  logic             emit, accept, fold_req;

  // A slot opens when the output register is empty or being drained.
  assign in_ready  = !rst && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign fold_req  = in_acc && is_fold_op(op_e'(in_op));
  assign count_inc = (count == CNT_MAX) ? count : count + CNT_ONE;

  logic_prim_alu #(.WIDTH(WIDTH)) u_alu (
    .op   (in_op),
    .a    (in_a),
    .b    (in_b),
    .en   (in_en),
    .data (alu_data),
    .oe   (alu_oe)
  );

  // Fold the incoming operand into the accumulator with the latched op.
  always_comb begin
    folded = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      folded[i] = base_op(acc_op, acc[i], in_a[i]);
    end
  end

  // Packet FSM next state and the result to load into the output register.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    acc_op_nxt = acc_op;
    count_nxt  = count;
    emit       = 1'b0;
    emit_data  = {WIDTH{1'b0}};
    emit_oe    = {WIDTH{1'b1}};
    emit_count = CNT_ONE;
    if (accept) begin
      if (state == ST_ACCUM) begin
        // Later beats of a packet ignore in_op/in_acc.
        if (in_last) begin
          emit       = 1'b1;
          emit_data  = is_inverted(acc_op) ? ~folded : folded;
          emit_count = count_inc;
          state_nxt  = ST_IDLE;
          acc_nxt    = {WIDTH{1'b0}};
          count_nxt  = {CNT_W{1'b0}};
        end else begin
          acc_nxt   = folded;
          count_nxt = count_inc;
        end
      end else if (fold_req) begin
        if (in_last) begin
          emit      = 1'b1;
          emit_data = is_inverted(op_e'(in_op)) ? ~in_a : in_a;
        end else begin
          state_nxt  = ST_ACCUM;
          acc_nxt    = in_a;
          acc_op_nxt = op_e'(in_op);
          count_nxt  = CNT_ONE;
        end
      end else begin
        emit      = 1'b1;
        emit_data = alu_data;
        emit_oe   = alu_oe;
      end
    end else begin
      state_nxt = state;
    end
  end

  // Packet state, accumulator, latched opcode and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      acc    <= {WIDTH{1'b0}};
      acc_op <= OP_AND;
      count  <= {CNT_W{1'b0}};
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      acc_op <= acc_op_nxt;
      count  <= count_nxt;
    end
  end

  // Output register: load on emit, drop valid on a drain with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_oe    <= {WIDTH{1'b0}};
      out_count <= {CNT_W{1'b0}};
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= emit_data;
      out_oe    <= emit_oe;
      out_count <= emit_count;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
